alu_mdu: RTL

//  Parametrised, registered successor to the combinational 16-bit ALU. It adds a multi-cycle

---
 rtl/alu_mdu.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_mdu.sv
// alu_mdu: registered Hack-style ALU plus an iterative unsigned MUL/DIVU/REMU unit behind valid/ready.
// Build option ALU_MDU_DIV_EN adds the restoring divider; without it op 10/11 return 0 with err set.
module alu_mdu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       op,
  input  logic [5:0]       ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             zr,
  output logic             ng,
  output logic             err
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [1:0]    OP_ALU   = 2'b00;
  localparam logic [1:0]    OP_MUL   = 2'b01;
`ifdef ALU_MDU_DIV_EN
  localparam logic [1:0]    OP_DIVU  = 2'b10;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  // x: multiplicand (MUL) or dividend shifting into quotient (DIV); y: multiplier or divisor
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] mul_acc_s;
  logic [WIDTH-1:0] fin_res_s;
  logic             fin_err_s;

  function automatic logic [WIDTH-1:0] hack_alu(
    input logic [5:0]       c,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    logic [WIDTH-1:0] xo;
    logic [WIDTH-1:0] yo;
    logic [WIDTH-1:0] fo;
    xo = c[5] ? {WIDTH{1'b0}} : x;
    xo = c[4] ? ~xo : xo;
    yo = c[3] ? {WIDTH{1'b0}} : y;
    yo = c[2] ? ~yo : yo;
    fo = c[1] ? (xo + yo) : (xo & yo);
    return c[0] ? ~fo : fo;
  endfunction

  // One shift-add step: add the multiplicand when the current multiplier bit is set.
  always_comb begin
    mul_acc_s = y_q[0] ? (acc_q + x_q) : acc_q;
  end

`ifdef ALU_MDU_DIV_EN
  logic [WIDTH:0]   rem_sh_s;
  logic             div_ge_s;
  logic [WIDTH-1:0] rem_next_s;
  logic [WIDTH-1:0] quo_next_s;

  // One restoring-division step; a zero divisor naturally yields all-ones quotient and remainder=a.
  always_comb begin
    rem_sh_s   = {acc_q, x_q[WIDTH-1]};
    div_ge_s   = (rem_sh_s >= {1'b0, y_q});
    rem_next_s = div_ge_s ? (rem_sh_s[WIDTH-1:0] - y_q) : rem_sh_s[WIDTH-1:0];
    quo_next_s = {x_q[WIDTH-2:0], div_ge_s};
  end
`endif

  // Next-state, datapath and result selection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    x_d       = x_q;
    y_d       = y_q;
    acc_d     = acc_q;
    result_d  = result_q;
    err_d     = err_q;
    fin_res_s = {WIDTH{1'b0}};
    fin_err_s = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          cnt_d = CNT_ZERO;
          op_d  = op;
          x_d   = a;
          y_d   = b;
          acc_d = {WIDTH{1'b0}};
          case (op)
            OP_ALU: begin
              result_d = hack_alu(ctrl, a, b);
              err_d    = 1'b0;
              state_d  = S_DONE;
            end
            OP_MUL: begin
              state_d = S_BUSY;
            end
            default: begin
`ifdef ALU_MDU_DIV_EN
              state_d = S_BUSY;
`else
              result_d = {WIDTH{1'b0}};
              err_d    = 1'b1;
              state_d  = S_DONE;
`endif
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end

      S_BUSY: begin
        cnt_d = cnt_q + CNT_ONE;
        case (op_q)
          OP_MUL: begin
            acc_d     = mul_acc_s;
            x_d       = x_q << 1;
            y_d       = y_q >> 1;
            fin_res_s = mul_acc_s;
            fin_err_s = 1'b0;
          end
          default: begin
`ifdef ALU_MDU_DIV_EN
            acc_d     = rem_next_s;
            x_d       = quo_next_s;
            fin_res_s = (op_q == OP_DIVU) ? quo_next_s : rem_next_s;
            fin_err_s = (y_q == {WIDTH{1'b0}});
`else
            fin_res_s = {WIDTH{1'b0}};
            fin_err_s = 1'b1;
`endif
          end
        endcase
        if (cnt_q == CNT_LAST) begin
          result_d = fin_res_s;
          err_d    = fin_err_s;
          state_d  = S_DONE;
        end else begin
          state_d = S_BUSY;
        end
      end

      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= CNT_ZERO;
      op_q     <= 2'b00;
      x_q      <= {WIDTH{1'b0}};
      y_q      <= {WIDTH{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      result_q <= {WIDTH{1'b0}};
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      x_q      <= x_d;
      y_q      <= y_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign res_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign err       = err_q;
  assign zr        = (result_q == {WIDTH{1'b0}});
  assign ng        = result_q[WIDTH-1];

endmodule
